// File: rtl/reglist_encoder.sv
// reglist_encoder: serialises an LDM/STM register mask into register numbers with a valid/ack handshake; REGLIST_COUNT_EN adds a registered popcount of the mask
module reglist_encoder #(
    parameter int LIST_W     = 16,
    parameter int IDX_W      = 4,
    parameter bit DESCENDING = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LIST_W-1:0] reg_list,
    output logic              ready,
    output logic              reg_valid,
    output logic [IDX_W-1:0]  reg_num,
    input  logic              reg_ack,
    output logic              last,
    output logic              done,
    output logic              pc_in_list,
    output logic [IDX_W:0]    count
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
    state_t            state_q, state_d;
    logic [LIST_W-1:0] pending_q, pending_d;
    logic              pc_q, pc_d;
    logic [IDX_W-1:0]  enc;
    logic              single;
    logic              accept;
    assign accept = (state_q == IDLE) && start;
    assign single = (pending_q & (pending_q - LIST_W'(1))) == '0;
    // priority encode of the pending mask; the last match in scan order wins
    always_comb begin
        enc = '0;
        for (int i = 0; i < LIST_W; i++) begin
            if (pending_q[DESCENDING ? i : LIST_W-1-i]) enc = IDX_W'(DESCENDING ? i : LIST_W-1-i);
        end
    end
    // state, pending mask and captured PC flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            pc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            pc_q      <= pc_d;
        end
    end
    // next state: load on accepted start, retire one register per ack
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pc_d      = pc_q;
        case (state_q)
            IDLE: if (start) begin
                pending_d = reg_list;
                pc_d      = reg_list[LIST_W-1];
                state_d   = (reg_list == '0) ? DONE : EMIT;
            end
            EMIT: if (reg_ack) begin
                pending_d = pending_q & ~(LIST_W'(1) << enc);
                state_d   = single ? DONE : EMIT;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs decoded from registered state only, so they stay stable while ack is low
    always_comb begin
        ready      = state_q == IDLE;
        reg_valid  = state_q == EMIT;
        reg_num    = reg_valid ? enc : '0;
        last       = reg_valid && single;
        done       = state_q == DONE;
        pc_in_list = pc_q;
    end
`ifdef REGLIST_COUNT_EN
    logic [IDX_W:0] count_q, count_d, pop;
    // popcount of the incoming mask
    always_comb begin
        pop = '0;
        for (int i = 0; i < LIST_W; i++) pop = pop + (IDX_W+1)'(reg_list[i]);
    end
    // count captured on accepted start and held for base-address offset
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign count_d = accept ? pop : count_q;
    assign count   = count_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign count         = '0;
`endif
endmodule

// File: tb/tb_reglist_encoder.sv
// tb_reglist_encoder: random and directed checks of ascending and descending encoders against a queue model
module tb_reglist_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, reg_ack = 1'b0;
    logic [15:0] reg_list = '0;
    logic        a_ready, a_valid, a_last, a_done, a_pc;
    logic [3:0]  a_num;
    logic [4:0]  a_count;
    logic        d_ready, d_valid, d_last, d_done, d_pc;
    logic [3:0]  d_num;
    logic [4:0]  d_count;
    int          n_cmp = 0, n_err = 0;
    bit          armed = 1'b0;
    int          qa[$], qd[$];
    bit          m_idle = 1'b1, m_done = 1'b0, m_pc = 1'b0;
    int          m_cnt = 0;

    always #5 clk = ~clk;

    reglist_encoder #(.LIST_W(16), .IDX_W(4), .DESCENDING(1'b0)) u_asc (
        .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
        .ready(a_ready), .reg_valid(a_valid), .reg_num(a_num), .reg_ack(reg_ack),
        .last(a_last), .done(a_done), .pc_in_list(a_pc), .count(a_count));

    reglist_encoder #(.LIST_W(16), .IDX_W(4), .DESCENDING(1'b1)) u_desc (
        .clk(clk), .reset(reset), .start(start), .reg_list(reg_list),
        .ready(d_ready), .reg_valid(d_valid), .reg_num(d_num), .reg_ack(reg_ack),
        .last(d_last), .done(d_done), .pc_in_list(d_pc), .count(d_count));

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: the remaining registers of the current list as queues in emission order
    always @(posedge clk) begin
        if (reset) begin
            qa.delete(); qd.delete();
            m_idle = 1'b1; m_done = 1'b0; m_pc = 1'b0; m_cnt = 0;
        end else if (m_done) begin
            m_done = 1'b0; m_idle = 1'b1;
        end else if (qa.size() > 0) begin
            if (reg_ack) begin
                void'(qa.pop_front()); void'(qd.pop_front());
                if (qa.size() == 0) m_done = 1'b1;
            end
        end else if (m_idle && start) begin
            for (int i = 0; i < 16; i++) if (reg_list[i]) begin qa.push_back(i); qd.push_front(i); end
            m_pc = reg_list[15];
`ifdef REGLIST_COUNT_EN
            m_cnt = $countones(reg_list);
`else
            m_cnt = 0;
`endif
            m_idle = 1'b0;
            m_done = qa.size() == 0;
        end
    end

    // every-cycle comparison of both encoders against the model
    always @(negedge clk) begin
        if (armed) begin
            chk("ready",    a_ready, int'(m_idle));
            chk("valid",    a_valid, int'(qa.size() > 0));
            chk("num_asc",  a_num,   qa.size() > 0 ? qa[0] : 0);
            chk("last",     a_last,  int'(qa.size() == 1));
            chk("done",     a_done,  int'(m_done));
            chk("pc",       a_pc,    int'(m_pc));
            chk("count",    a_count, m_cnt);
            chk("d_ready",  d_ready, int'(m_idle));
            chk("d_valid",  d_valid, int'(qd.size() > 0));
            chk("num_desc", d_num,   qd.size() > 0 ? qd[0] : 0);
            chk("d_last",   d_last,  int'(qd.size() == 1));
            chk("d_done",   d_done,  int'(m_done));
            chk("d_pc",     d_pc,    int'(m_pc));
            chk("d_count",  d_count, m_cnt);
        end
    end

    task automatic step(input logic s, input logic [15:0] l, input logic a, input logic r);
        start = s; reg_list = l; reg_ack = a; reset = r;
        @(posedge clk); #1;
    endtask

    int exp3, exp2;
    initial begin
`ifdef REGLIST_COUNT_EN
        exp3 = 3; exp2 = 2;
`else
        exp3 = 0; exp2 = 0;
`endif
        step(0, '0, 0, 1); step(0, '0, 0, 1);
        armed = 1'b1;
        chk("rst_ready", a_ready, 1); chk("rst_valid", a_valid, 0);
        chk("rst_num", a_num, 0); chk("rst_count", a_count, 0);
        // empty list
        step(1, 16'h0000, 1, 0);
        chk("empty_done", a_done, 1); chk("empty_valid", a_valid, 0); chk("empty_ready", a_ready, 0);
        step(0, '0, 0, 0);
        chk("empty_ready2", a_ready, 1); chk("empty_count", a_count, 0);
        // 8011 with ack held
        step(1, 16'h8011, 1, 0);
        chk("l1_asc", a_num, 0); chk("l1_desc", d_num, 15); chk("l1_last", a_last, 0);
        chk("l1_pc", a_pc, 1); chk("l1_count", a_count, exp3);
        step(0, '0, 1, 0);
        chk("l2_asc", a_num, 4); chk("l2_desc", d_num, 4);
        step(0, '0, 1, 0);
        chk("l3_asc", a_num, 15); chk("l3_last", a_last, 1); chk("l3_desc", d_num, 0); chk("l3_dlast", d_last, 1);
        step(0, '0, 1, 0);
        chk("l4_done", a_done, 1);
        step(0, '0, 0, 0);
        // 0006 with ack stalled
        step(1, 16'h0006, 0, 0);
        chk("s1_num", a_num, 1); chk("s1_valid", a_valid, 1);
        step(0, '0, 0, 0);
        chk("s2_num", a_num, 1);
        step(0, '0, 0, 0);
        chk("s3_num", a_num, 1);
        step(0, '0, 1, 0);
        chk("s4_num", a_num, 2); chk("s4_last", a_last, 1);
        step(0, '0, 1, 0);
        chk("s5_done", a_done, 1);
        step(0, '0, 0, 0);
        // start ignored while busy
        step(1, 16'h0003, 1, 0);
        step(1, 16'hFFFF, 1, 0);
        chk("i2_num", a_num, 1); chk("i2_last", a_last, 1);
        step(1, 16'hFFFF, 1, 0);
        chk("i3_done", a_done, 1); chk("i3_count", a_count, exp2); chk("i3_pc", a_pc, 0);
        step(0, '0, 0, 0);
        // reset mid-sequence
        step(1, 16'h00F0, 1, 0);
        chk("r1_num", a_num, 4);
        step(0, '0, 1, 1);
        chk("r2_ready", a_ready, 1); chk("r2_valid", a_valid, 0); chk("r2_done", a_done, 0); chk("r2_pc", a_pc, 0);
        step(0, '0, 1, 0);
        chk("r3_done", a_done, 0);
        // random traffic
        for (int c = 0; c < 4000; c++) begin
            logic [15:0] l;
            int sel;
            sel = $urandom_range(0, 9);
            l = sel == 0 ? 16'h0 : sel == 1 ? 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
            step($urandom_range(0, 3) == 0, l, $urandom_range(0, 9) < 7, $urandom_range(0, 149) == 0);
        end
        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
